// File: rtl/tmds_pkg.sv
// Shared TMDS lane constants: DVI control tokens and the
// alignment state machine encoding.
package tmds_pkg;

    localparam logic [9:0] TOKEN_C00 = 10'h354;
    localparam logic [9:0] TOKEN_C01 = 10'h0AB;
    localparam logic [9:0] TOKEN_C10 = 10'h154;
    localparam logic [9:0] TOKEN_C11 = 10'h2AB;

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_e;

endpackage

// File: rtl/tmds_channel_decoder_if.sv
// Serial input and decoded character outputs of one TMDS lane.
// master = stream source / consumer, slave = the decoder.
interface tmds_channel_decoder_if;

    logic       tmds_in;
    logic [7:0] data_out;
    logic       c0;
    logic       c1;
    logic       de_out;
    logic       word_valid;
    logic       locked;

    modport master (
        output tmds_in,
        input  data_out, c0, c1, de_out, word_valid, locked
    );

    modport slave (
        input  tmds_in,
        output data_out, c0, c1, de_out, word_valid, locked
    );

endinterface

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS character decode: 10-bit symbol to
// control code or 8-bit pixel byte.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] q,
    output logic [7:0] data,
    output logic       c0,
    output logic       c1,
    output logic       is_ctrl
);

    logic [7:0] d;

    always_comb begin
        // q[9] marks an inverted payload, q[8] selects XOR vs XNOR chaining
        d       = q[9] ? ~q[7:0] : q[7:0];
        data    = '0;
        data[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end

        is_ctrl  = 1'b1;
        {c1, c0} = 2'b00;
        unique case (q)
            TOKEN_C00: {c1, c0} = 2'b00;
            TOKEN_C01: {c1, c0} = 2'b01;
            TOKEN_C10: {c1, c0} = 2'b10;
            TOKEN_C11: {c1, c0} = 2'b11;
            default:   is_ctrl  = 1'b0;
        endcase
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// TMDS lane receiver: deserializer, token-based word alignment
// and registered character decode with lock supervision.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT       = 4,
    parameter int MAX_ACTIVE_WORDS = 4096
) (
    input  logic                  clk,
    input  logic                  n_rst,
    tmds_channel_decoder_if.slave bus
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int AW = $clog2(MAX_ACTIVE_WORDS + 1);
    localparam logic [MW-1:0] LOCK_MAX = MW'(LOCK_COUNT);
    localparam logic [MW-1:0] M_ONE    = MW'(1);
    localparam logic [AW-1:0] ACT_MAX  = AW'(MAX_ACTIVE_WORDS);
    localparam logic [AW-1:0] A_ONE    = AW'(1);

    state_e        state_q, state_d;
    logic [9:0]    sr_q, sr_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [MW-1:0] match_cnt_q, match_cnt_d;
    logic [AW-1:0] active_cnt_q, active_cnt_d;
    logic [7:0]    data_q, data_d;
    logic          c0_q, c0_d;
    logic          c1_q, c1_d;
    logic          de_q, de_d;
    logic          valid_q, valid_d;
    logic          locked_q, locked_d;

    logic [7:0]    sym_data;
    logic          sym_c0;
    logic          sym_c1;
    logic          sym_ctrl;
    logic          boundary;
    logic          verify_done;
    logic          act_full;

    tmds_symbol_decode u_decode (
        .q       (sr_q),
        .data    (sym_data),
        .c0      (sym_c0),
        .c1      (sym_c1),
        .is_ctrl (sym_ctrl)
    );

    assign boundary    = (bit_cnt_q == 4'd9);
    assign verify_done = ((match_cnt_q + M_ONE) == LOCK_MAX);
    assign act_full    = (active_cnt_q == ACT_MAX);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= SEARCH;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            match_cnt_q  <= '0;
            active_cnt_q <= '0;
            data_q       <= '0;
            c0_q         <= 1'b0;
            c1_q         <= 1'b0;
            de_q         <= 1'b0;
            valid_q      <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            match_cnt_q  <= match_cnt_d;
            active_cnt_q <= active_cnt_d;
            data_q       <= data_d;
            c0_q         <= c0_d;
            c1_q         <= c1_d;
            de_q         <= de_d;
            valid_q      <= valid_d;
            locked_q     <= locked_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SEARCH: begin
                if (sym_ctrl) state_d = VERIFY;
            end
            VERIFY: begin
                if (boundary) begin
                    if (!sym_ctrl)        state_d = SEARCH;
                    else if (verify_done) state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (boundary && !sym_ctrl && act_full) state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase
    end

    always_comb begin
        sr_d         = {bus.tmds_in, sr_q[9:1]};
        bit_cnt_d    = boundary ? 4'd0 : bit_cnt_q + 4'd1;
        match_cnt_d  = match_cnt_q;
        active_cnt_d = active_cnt_q;
        data_d       = data_q;
        c0_d         = c0_q;
        c1_d         = c1_q;
        de_d         = de_q;
        valid_d      = 1'b0;
        locked_d     = (state_d == LOCKED);
        unique case (state_q)
            SEARCH: begin
                bit_cnt_d    = '0;
                match_cnt_d  = sym_ctrl ? M_ONE : '0;
                active_cnt_d = '0;
            end
            VERIFY: begin
                if (boundary) begin
                    match_cnt_d = sym_ctrl ? match_cnt_q + M_ONE : '0;
                end
            end
            LOCKED: begin
                if (boundary && sym_ctrl) begin
                    active_cnt_d = '0;
                    de_d         = 1'b0;
                    c0_d         = sym_c0;
                    c1_d         = sym_c1;
                    valid_d      = 1'b1;
                end else if (boundary && act_full) begin
                    // too long without a blanking token: alignment is suspect
                    active_cnt_d = '0;
                    match_cnt_d  = '0;
                    bit_cnt_d    = '0;
                end else if (boundary) begin
                    active_cnt_d = active_cnt_q + A_ONE;
                    de_d         = 1'b1;
                    data_d       = sym_data;
                    valid_d      = 1'b1;
                end
            end
            default: begin
                bit_cnt_d = '0;
            end
        endcase
    end

    assign bus.data_out   = data_q;
    assign bus.c0         = c0_q;
    assign bus.c1         = c1_q;
    assign bus.de_out     = de_q;
    assign bus.word_valid = valid_q;
    assign bus.locked     = locked_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: directed vector table, lock
// corner sequences, and random streams against a timeline model.
module tb_tmds_channel_decoder;

    localparam int LOCK = 4;
    localparam int MAXW = 4096;

    typedef struct packed {
        logic [7:0] data;
        logic       c0;
        logic       c1;
        logic       de;
        logic       wv;
        logic       lk;
    } obs_t;

    typedef struct {
        logic [9:0] w;
        obs_t       e;
    } vec_t;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [9:0] toks [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    obs_t       hist [10];
    bit         stim [$];
    obs_t       exp_q [$];
    vec_t       vt [10];

    always #5 clk = ~clk;

    tmds_channel_decoder_if bus ();

    tmds_channel_decoder #(
        .LOCK_COUNT       (LOCK),
        .MAX_ACTIVE_WORDS (MAXW)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    function automatic obs_t rd();
        obs_t o;
        o.data = bus.data_out;
        o.c0   = bus.c0;
        o.c1   = bus.c1;
        o.de   = bus.de_out;
        o.wv   = bus.word_valid;
        o.lk   = bus.locked;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic b);
        bus.tmds_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int k = 0; k < 10; k++) begin
            step(w[k]);
            hist[k] = rd();
        end
    endtask

    function automatic int hist_wv();
        int n = 0;
        for (int k = 0; k < 10; k++) n += int'(hist[k].wv);
        return n;
    endfunction

    task automatic do_reset();
        n_rst = 1'b0;
        repeat (3) step(1'($urandom_range(0, 1)));
        n_rst = 1'b1;
    endtask

    function automatic int tok_code(input logic [9:0] w);
        for (int c = 0; c < 4; c++) if (w == toks[c]) return c;
        return -1;
    endfunction

    function automatic logic [7:0] dec_ref(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] x;
        d = w[9] ? ~w[7:0] : w[7:0];
        x = d ^ {d[6:0], 1'b0};
        if (!w[8]) x[7:1] = ~x[7:1];
        return x;
    endfunction

    function automatic logic [9:0] enc(input logic [7:0] b, input bit xr,
                                       input bit inv);
        logic [7:0] m;
        m[0] = b[0];
        for (int i = 1; i < 8; i++) m[i] = xr ? (m[i-1] ^ b[i]) : ~(m[i-1] ^ b[i]);
        return {inv, xr, inv ? ~m : m};
    endfunction

    function automatic logic [9:0] win(input int n);
        logic [9:0] w = '0;
        for (int k = 0; k < 10; k++) if (n - k >= 0) w[9-k] = stim[n-k];
        return w;
    endfunction

    // Timeline model over the whole bit stream: window n is the
    // 10 most recent bits; its outcome is visible two edges later.
    task automatic build_expect();
        int         mode = 0;
        int         cnt  = 0;
        int         nxt  = 0;
        int         act  = 0;
        int         c;
        logic [9:0] w;
        obs_t       cur  = '0;
        exp_q.delete();
        exp_q.push_back(cur);
        for (int n = 0; n < stim.size() - 1; n++) begin
            w      = win(n);
            c      = tok_code(w);
            cur.wv = 1'b0;
            if (mode == 0) begin
                if (c >= 0) begin
                    mode = 1;
                    cnt  = 1;
                    nxt  = n + 10;
                end
            end else if (n == nxt) begin
                nxt = n + 10;
                if (mode == 1) begin
                    if (c < 0) mode = 0;
                    else begin
                        cnt++;
                        if (cnt == LOCK) begin
                            mode = 2;
                            act  = 0;
                        end
                    end
                end else if (c >= 0) begin
                    act      = 0;
                    cur.wv   = 1'b1;
                    cur.de   = 1'b0;
                    cur.c0   = c[0];
                    cur.c1   = c[1];
                end else if (act == MAXW) begin
                    mode = 0;
                end else begin
                    act++;
                    cur.wv   = 1'b1;
                    cur.de   = 1'b1;
                    cur.data = dec_ref(w);
                end
            end
            cur.lk = (mode == 2);
            exp_q.push_back(cur);
        end
    endtask

    task automatic rand_run(input int nwords, input int slip_at);
        logic [9:0] w;
        stim.delete();
        repeat ($urandom_range(0, 9)) stim.push_back(1'($urandom_range(0, 1)));
        for (int k = 0; k < nwords; k++) begin
            if (k == slip_at)
                repeat ($urandom_range(1, 9)) stim.push_back(1'($urandom_range(0, 1)));
            if (k < 6 || (k >= slip_at && k < slip_at + 6) || $urandom_range(0, 3) == 0) begin
                w = toks[$urandom_range(0, 3)];
            end else begin
                do w = enc(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                while (tok_code(w) >= 0);
            end
            for (int b = 0; b < 10; b++) stim.push_back(w[b]);
        end
        build_expect();
        do_reset();
        for (int i = 0; i < stim.size(); i++) begin
            step(stim[i]);
            chk($sformatf("rand_step%0d", i), rd(), exp_q[i]);
        end
    endtask

    initial begin
        int n;
        int l;
        vt[0] = '{10'h354, '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}};
        vt[1] = '{10'h100, '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1}};
        vt[2] = '{10'h2FF, '{8'hFE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1}};
        vt[3] = '{10'h2AB, '{8'hFE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1}};
        vt[4] = '{10'h1AB, '{8'hFD, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}};
        vt[5] = '{10'h0AB, '{8'hFD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}};
        vt[6] = '{10'h0FF, '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1}};
        vt[7] = '{10'h154, '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}};
        vt[8] = '{10'h1FF, '{8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1}};
        vt[9] = '{10'h0AA, '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1}};
        bus.tmds_in = 1'b0;

        // reset with random serial input
        n_rst = 1'b0;
        step(1'($urandom_range(0, 1)));
        chk("reset_first", rd(), 16'h0);
        repeat (2) step(1'($urandom_range(0, 1)));
        chk("reset_held", rd(), 16'h0);
        n_rst = 1'b1;

        // acquire on 0x354 then decode table
        repeat (3) step(1'($urandom_range(0, 1)));
        repeat (3) send_word(10'h354);
        send_word(10'h354);
        chk("acq_not_yet", 16'(hist[9].lk), 16'h0);
        for (int i = 0; i <= 10; i++) begin
            send_word(i < 10 ? vt[i].w : 10'h354);
            if (i == 0) begin
                chk("acq_locked", 16'(hist[0].lk), 16'h1);
                chk("acq_4th_no_wv", 16'(hist[0].wv), 16'h0);
            end else begin
                chk($sformatf("vec%0d", i - 1), hist[0], vt[i-1].e);
                chk($sformatf("vec%0d_strobe", i - 1), 16'(hist_wv()), 16'h1);
            end
        end

        // verification failure, then reacquire
        do_reset();
        n = 0;
        l = 0;
        send_word(10'h0AB);
        send_word(10'h0AB);
        send_word(10'h100);
        for (int k = 0; k < 4; k++) begin
            send_word(10'h0AB);
            n += hist_wv();
            for (int j = 0; j < 10; j++) l += int'(hist[j].lk);
        end
        chk("vfail_no_wv", 16'(n), 16'h0);
        chk("vfail_no_lock", 16'(l), 16'h0);
        send_word(10'h0AB);
        chk("vfail_relock", 16'(hist[0].lk), 16'h1);

        // active-word limit, with one token resetting the count
        do_reset();
        repeat (5) send_word(10'h354);
        n = 0;
        repeat (2048) begin send_word(10'h100); n += hist_wv(); end
        chk("loss_segA_wv", 16'(n), 16'd2048);
        send_word(10'h354);
        chk("loss_tok_wv", 16'(hist_wv()), 16'h1);
        n = 0;
        repeat (2049) begin send_word(10'h100); n += hist_wv(); end
        chk("loss_segC_wv", 16'(n), 16'd2049);
        chk("loss_token_keeps", 16'(hist[0].lk), 16'h1);
        n = 0;
        repeat (2047) begin send_word(10'h100); n += hist_wv(); end
        chk("loss_segD_wv", 16'(n), 16'd2047);
        send_word(10'h100);
        chk("loss_4096th", {14'h0, hist[0].wv, hist[0].lk}, 16'h3);
        send_word(10'h100);
        chk("loss_4097th", {14'h0, hist[0].wv, hist[0].lk}, 16'h0);
        chk("loss_stays", 16'(hist[9].lk), 16'h0);

        // reset in the middle of a data word while locked
        do_reset();
        repeat (5) send_word(10'h354);
        send_word(10'h2FF);
        for (int k = 0; k < 5; k++) step(k == 0 ? 1'b1 : 1'b0);
        chk("midrst_before", {8'h0, rd()} & 16'h1FD5, 16'h1FD5 & {8'h0, 8'hFE, 5'b00101});
        n_rst = 1'b0;
        step(1'b1);
        chk("midrst_zero", rd(), 16'h0);
        n_rst = 1'b1;
        repeat (4) send_word(10'h154);
        chk("midrst_3tok", 16'(hist[0].lk), 16'h0);
        send_word(10'h154);
        chk("midrst_relock", 16'(hist[0].lk), 16'h1);

        rand_run(100, 3);
        rand_run(100, 40);
        rand_run(100, 70);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
